// File: rtl/execute_muldiv.sv
// RV32M-style multiply/divide execute unit.
// Multiplies complete after a fixed latency; divides iterate one
// quotient bit per cycle (restoring radix-2) on operand magnitudes.
module execute_muldiv #(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stop,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] data_0,
   input  logic [XLEN-1:0] data_1,
   input  logic [4:0]      in_reg_d,
   output logic            busy,
   output logic            out_valid,
   output logic [4:0]      out_reg_d,
   output logic [XLEN-1:0] alu_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int CNT_W = $clog2(XLEN + MUL_LATENCY + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   // Operands latched at accept; stable until completion
   logic [1:0]       op_p0;
   logic [XLEN-1:0]  src0_p0, src1_p0;
   logic [4:0]       tag_p0;
   logic [XLEN-1:0]  quo_p0, rem_p0, dvsr_p0;
   logic             q_neg_p0, r_neg_p0;

   // Two's-complement negate when neg is set (magnitude / sign restore)
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   logic accept, is_signed, neg0, neg1, div_zero, div_ovf;
   assign accept    = in_valid && !stop && !flush && (state == S_IDLE || state == S_DONE);
   assign is_signed = !funct3[0];
   assign neg0      = is_signed && data_0[XLEN-1];
   assign neg1      = is_signed && data_1[XLEN-1];
   assign div_zero  = (data_1 == '0);
   assign div_ovf   = is_signed && (data_0 == MOST_NEG) && (data_1 == '1);

   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign out_valid = (state == S_DONE);

   // Multiply: single-cycle latency multiplies straight off the inputs
   logic [1:0]        mop;
   logic [XLEN-1:0]   ma, mb;
   logic              ma_sgn, mb_sgn;
   logic [2*XLEN-1:0] ma_w, mb_w, prod;
   logic [XLEN-1:0]   mul_res;
   assign mop     = (MUL_LATENCY == 1) ? funct3[1:0] : op_p0;
   assign ma      = (MUL_LATENCY == 1) ? data_0 : src0_p0;
   assign mb      = (MUL_LATENCY == 1) ? data_1 : src1_p0;
   assign ma_sgn  = (mop != 2'b11);
   assign mb_sgn  = (mop == 2'b01);
   assign ma_w    = {{XLEN{ma_sgn & ma[XLEN-1]}}, ma};
   assign mb_w    = {{XLEN{mb_sgn & mb[XLEN-1]}}, mb};
   assign prod    = ma_w * mb_w;
   assign mul_res = (mop == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   // Divide step: shift next dividend bit into the partial remainder and trial-subtract
   logic [XLEN:0]   trial;
   logic            ge;
   logic [XLEN-1:0] rem_nx, quo_nx, div_res;
   assign trial   = {rem_p0, quo_p0[XLEN-1]} - {1'b0, dvsr_p0};
   assign ge      = !trial[XLEN];
   assign rem_nx  = ge ? trial[XLEN-1:0] : {rem_p0[XLEN-2:0], quo_p0[XLEN-1]};
   assign quo_nx  = {quo_p0[XLEN-2:0], ge};
   assign div_res = op_p0[1] ? apply_sign(rem_nx, r_neg_p0) : apply_sign(quo_nx, q_neg_p0);

   // Control and result registers: rst > stop > flush > accept > sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         alu_out   <= '0;
         out_reg_d <= '0;
      end else if (!stop) begin
         if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else if (accept) begin
            cnt <= '0;
            if (!funct3[2]) begin
               if (MUL_LATENCY == 1) begin
                  state     <= S_DONE;
                  alu_out   <= mul_res;
                  out_reg_d <= in_reg_d;
               end else begin
                  state <= S_MUL;
                  cnt   <= CNT_W'(1);
               end
            end else if (div_zero) begin
               state     <= S_DONE;
               alu_out   <= funct3[1] ? data_0 : '1;
               out_reg_d <= in_reg_d;
            end else if (div_ovf) begin
               state     <= S_DONE;
               alu_out   <= funct3[1] ? '0 : data_0;
               out_reg_d <= in_reg_d;
            end else begin
               state <= S_DIV;
            end
         end else begin
            case (state)
               S_MUL: begin
                  if (cnt == CNT_W'(MUL_LATENCY - 1)) begin
                     state     <= S_DONE;
                     alu_out   <= mul_res;
                     out_reg_d <= tag_p0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DIV: begin
                  if (cnt == CNT_W'(XLEN - 1)) begin
                     state     <= S_DONE;
                     alu_out   <= div_res;
                     out_reg_d <= tag_p0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Datapath registers: latch on accept, iterate while dividing
   always_ff @(posedge clk) begin
      if (!stop && !flush) begin
         if (accept) begin
            op_p0    <= funct3[1:0];
            src0_p0  <= data_0;
            src1_p0  <= data_1;
            tag_p0   <= in_reg_d;
            quo_p0   <= apply_sign(data_0, neg0);
            dvsr_p0  <= apply_sign(data_1, neg1);
            rem_p0   <= '0;
            q_neg_p0 <= neg0 ^ neg1;
            r_neg_p0 <= neg0;
         end else if (state == S_DIV) begin
            quo_p0 <= quo_nx;
            rem_p0 <= rem_nx;
         end
      end
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed cases plus randomized ops against a
// plain-arithmetic reference model.
module tb_execute_muldiv;

   localparam int XLEN = 32;
   localparam int ML   = 2;

   logic            clk = 1'b0;
   logic            rst, stop, flush, in_valid;
   logic [2:0]      funct3;
   logic [XLEN-1:0] data_0, data_1;
   logic [4:0]      in_reg_d;
   logic            busy, out_valid;
   logic [4:0]      out_reg_d;
   logic [XLEN-1:0] alu_out;

   int checks   = 0;
   int failures = 0;

   execute_muldiv #(.XLEN(XLEN), .MUL_LATENCY(ML)) dut (
      .clk(clk), .rst(rst), .stop(stop), .flush(flush), .in_valid(in_valid),
      .funct3(funct3), .data_0(data_0), .data_1(data_1), .in_reg_d(in_reg_d),
      .busy(busy), .out_valid(out_valid), .out_reg_d(out_reg_d), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference result from the RV M-extension rules using 64-bit arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      logic [63:0] p;
      logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return ML;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Issue one op, optionally pausing it, and check latency/result/tag/busy.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input int stop_at, input int stop_len, input bit hold_done);
      int n = 0;
      int lat;
      int busy_bad = 0;
      logic [31:0] exp_res = ref_result(f3, a, b);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, 32'(busy), 32'd0);
      in_valid = 1'b1; funct3 = f3; data_0 = a; data_1 = b; in_reg_d = tag;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         if (!busy) busy_bad++;
         stop     = (stop_len > 0) && (lat >= stop_at) && (lat < stop_at + stop_len);
         in_valid = 1'($urandom);
         funct3   = 3'($urandom);
         data_0   = $urandom;
         data_1   = $urandom;
         in_reg_d = 5'($urandom);
         @(negedge clk);
         lat++;
      end
      stop = 1'b0; in_valid = 1'b0;
      check({name, "_lat"}, 32'(lat), 32'(ref_latency(f3, a, b) + stop_len));
      check({name, "_res"}, alu_out, exp_res);
      check({name, "_tag"}, 32'(out_reg_d), 32'(tag));
      check({name, "_busy"}, 32'(busy_bad), 32'd0);
      if (hold_done) begin
         stop = 1'b1;
         @(negedge clk);
         check({name, "_hold_v"}, 32'(out_valid), 32'd1);
         @(negedge clk);
         check({name, "_hold_v2"}, 32'(out_valid), 32'd1);
         check({name, "_hold_res"}, alu_out, exp_res);
         stop = 1'b0;
      end
      @(negedge clk);
      check({name, "_drop"}, 32'(out_valid), 32'd0);
      check({name, "_keep"}, alu_out, exp_res);
   endtask

   initial begin
      int cnt_v;
      rst = 1'b1; stop = 1'b0; flush = 1'b0; in_valid = 1'b0;
      funct3 = '0; data_0 = '0; data_1 = '0; in_reg_d = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_alu", alu_out, 32'd0);
      check("rst_tag", 32'(out_reg_d), 32'd0);

      run_op("mul7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0, 1'b0);
      check("mul7x-3_val", alu_out, 32'hFFFF_FFEB);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0, 1'b0);
      check("mulhu_val", alu_out, 32'hFFFF_FFFE);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0, 1'b0);
      check("mulh_val", alu_out, 32'h0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0, 1'b1);
      run_op("div-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 0, 1'b0);
      check("div-7/2_val", alu_out, 32'hFFFF_FFFD);
      run_op("rem-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, 0, 1'b1);
      check("rem-7/2_val", alu_out, 32'hFFFF_FFFF);
      run_op("divu9/0", 3'd5, 32'd9, 32'd0, 5'd9, 0, 0, 1'b0);
      check("divu9/0_val", alu_out, 32'hFFFF_FFFF);
      run_op("remu9/0", 3'd7, 32'd9, 32'd0, 5'd10, 0, 0, 1'b0);
      check("remu9/0_val", alu_out, 32'd9);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0, 1'b0);
      check("div_ovf_val", alu_out, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0, 1'b0);
      run_op("div_stop", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, 10, 4, 1'b0);
      run_op("mul_stop", 3'd0, 32'd1234, 32'd5678, 5'd14, 1, 3, 1'b0);

      // Flush mid-divide: no result, idle next cycle
      in_valid = 1'b1; funct3 = 3'd5; data_0 = 32'd1000; data_1 = 32'd7; in_reg_d = 5'd20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      cnt_v = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) cnt_v++;
      end
      check("flush_noresult", 32'(cnt_v), 32'd0);
      // Flush together with a request: flush wins
      flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_req_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("flush_req_valid", 32'(out_valid), 32'd0);

      // Reset mid-divide, asserted together with stop
      in_valid = 1'b1; funct3 = 3'd4; data_0 = 32'd100; data_1 = 32'd3; in_reg_d = 5'd21;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1; stop = 1'b1;
      @(negedge clk);
      rst = 1'b0; stop = 1'b0;
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_alu", alu_out, 32'd0);
      check("rstmid_tag", 32'(out_reg_d), 32'd0);
      run_op("mul3x4", 3'd0, 32'd3, 32'd4, 5'd22, 0, 0, 1'b0);
      check("mul3x4_val", alu_out, 32'd12);

      // Randomized operations across operand classes
      for (int k = 0; k < 60; k++) begin
         logic [2:0]  f3 = 3'($urandom_range(0, 7));
         logic [31:0] a  = $urandom;
         logic [31:0] b  = $urandom;
         case ($urandom_range(0, 5))
            0: ;
            1: b = 32'd0;
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
            4: b = 32'($urandom_range(1, 9));
            default: begin a = 32'hFFFF_FFFF; b = {1'b1, 31'($urandom)}; end
         endcase
         run_op("rnd", f3, a, b, 5'($urandom), 0, 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
